// File: rtl/i2c_dut_pkg.sv
// i2c_dut_pkg: shared constants for the I2C register target.
//   - FSM state encodings (state_t + ST_* constants)
//   - ACK/NACK bus levels
//   - position of the R/W bit within the address byte
package i2c_dut_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_ADDR     = 4'd1;
  localparam state_t ST_ADDR_ACK = 4'd2;
  localparam state_t ST_PTR      = 4'd3;
  localparam state_t ST_PTR_ACK  = 4'd4;
  localparam state_t ST_WR       = 4'd5;
  localparam state_t ST_WR_ACK   = 4'd6;
  localparam state_t ST_RD       = 4'd7;
  localparam state_t ST_RD_ACK   = 4'd8;
  localparam state_t ST_IGNORE   = 4'd9;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_dut_if.sv
// i2c_dut_if: synchronized view of the I2C bus.
//   scl_s/sda_s       : synchronized line levels
//   scl_rise/scl_fall : one-cycle pulses on synchronized scl edges
//   start/stop        : one-cycle START / STOP condition pulses
// master modport = producer (i2c_bus_sync), slave modport = consumer (FSM).
interface i2c_dut_if;
  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  modport master (output scl_s, sda_s, scl_rise, scl_fall, start, stop);
  modport slave  (input  scl_s, sda_s, scl_rise, scl_fall, start, stop);
endinterface

// File: rtl/i2c_dut_bus_sync.sv
// i2c_bus_sync: 2-flop synchronizers for scl/sda plus edge and START/STOP
// detection.
//   clk, rst_n : system clock, async active-low reset
//   scl, sda   : raw bus levels
//   bus        : synchronized levels and event pulses (master modport)
// Flops reset to 1 (idle bus level) so reset release on an idle bus
// produces no spurious edges.
module i2c_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  i2c_dut_if.master  bus
);

  logic [1:0] scl_ff, sda_ff;
  logic       scl_d, sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign bus.scl_s    = scl_ff[1];
  assign bus.sda_s    = sda_ff[1];
  assign bus.scl_rise =  scl_ff[1] & ~scl_d;
  assign bus.scl_fall = ~scl_ff[1] &  scl_d;
  // sda transitions only count as START/STOP while scl was high on both samples
  assign bus.start    = scl_ff[1] & scl_d &  sda_d & ~sda_ff[1];
  assign bus.stop     = scl_ff[1] & scl_d & ~sda_d &  sda_ff[1];

endmodule

// File: rtl/i2c_dut.sv
// i2c_dut: I2C target with NUM_REGS 8-bit registers behind an auto-
// incrementing pointer.  Write: addr(W), pointer, data...; read: addr(R),
// data... (pointer kept across STOP/START).
//   system_clock : sole clock (>= 10x SCL rate)
//   reset_n      : async active-low reset
//   sda, scl     : open-drain bus lines, driven only 0 or z
// Build option: define I2C_DUT_CLK_STRETCH_EN to hold scl low for
// STRETCH_CYCLES clocks after every ACK/NACK bit; otherwise scl is never
// driven.
module i2c_dut
  import i2c_dut_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h50,
  parameter int         NUM_REGS       = 16,
  parameter int         STRETCH_CYCLES = 8
) (
  input  logic system_clock,
  input  logic reset_n,
  inout  wire  sda,
  inout  wire  scl
);

  localparam int PW = $clog2(NUM_REGS);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
`ifdef I2C_DUT_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  i2c_dut_if bus ();

  i2c_bus_sync u_sync (
    .clk   (system_clock),
    .rst_n (reset_n),
    .scl   (scl),
    .sda   (sda),
    .bus   (bus)
  );

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    sreg;
  logic [7:0]    tx;
  logic          rw;
  logic          ack_in;
  logic          sda_oe;
  logic          scl_oe;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];
  logic [CW-1:0] stretch_cnt;

  wire in_byte   = state inside {ST_ADDR, ST_PTR, ST_WR, ST_RD};
  wire byte_done = (bit_cnt == 4'd8);
  wire ack_fall  = bus.scl_fall &&
                   (state inside {ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK, ST_RD_ACK});

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      ack_in  <= NACK;
      sda_oe  <= 1'b0;
      ptr     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (bus.start) begin
      state   <= ST_ADDR;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else if (bus.stop) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else begin
      // track sda over the whole high phase; the value held at scl fall is the ACK
      if (state == ST_RD_ACK && bus.scl_s) ack_in <= bus.sda_s;

      if (bus.scl_rise && in_byte && !byte_done) begin
        sreg    <= {sreg[6:0], bus.sda_s};
        bit_cnt <= bit_cnt + 1'b1;
      end

      // all sda updates happen here, i.e. while scl is low
      if (bus.scl_fall) begin
        case (state)
          ST_ADDR: if (byte_done) begin
            bit_cnt <= '0;
            if (sreg[7:1] == DEV_ADDR) begin
              state  <= ST_ADDR_ACK;
              rw     <= sreg[RW_BIT];
              sda_oe <= 1'b1;
            end else begin
              state  <= ST_IGNORE;
            end
          end
          ST_ADDR_ACK: begin
            if (rw) begin
              state  <= ST_RD;
              tx     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              state  <= ST_PTR;
              sda_oe <= 1'b0;
            end
          end
          ST_PTR: if (byte_done) begin
            ptr     <= sreg[PW-1:0];
            state   <= ST_PTR_ACK;
            sda_oe  <= 1'b1;
            bit_cnt <= '0;
          end
          ST_PTR_ACK: begin
            state  <= ST_WR;
            sda_oe <= 1'b0;
          end
          ST_WR: if (byte_done) begin
            regs[ptr] <= sreg;
            ptr       <= ptr + 1'b1;
            state     <= ST_WR_ACK;
            sda_oe    <= 1'b1;
            bit_cnt   <= '0;
          end
          ST_WR_ACK: begin
            state  <= ST_WR;
            sda_oe <= 1'b0;
          end
          ST_RD: begin
            if (byte_done) begin
              state   <= ST_RD_ACK;
              sda_oe  <= 1'b0;
              ptr     <= ptr + 1'b1;
              bit_cnt <= '0;
            end else begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
          ST_RD_ACK: begin
            if (ack_in == ACK) begin
              state  <= ST_RD;
              tx     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              state  <= ST_IGNORE;
              sda_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stretch counter never loads when stretching is compiled out, so scl stays z.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n)                  stretch_cnt <= '0;
    else if (STRETCH_EN && ack_fall) stretch_cnt <= CW'(STRETCH_CYCLES);
    else if (stretch_cnt != '0)    stretch_cnt <= stretch_cnt - 1'b1;
  end

  assign scl_oe = (stretch_cnt != '0);

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_dut.sv
// tb_i2c_dut: directed bus-controller bench for i2c_dut with a scoreboard
// of expected ACK bits and read bytes.  Define I2C_DUT_CLK_STRETCH_EN to
// also check clock stretching.
module tb_i2c_dut;
  import i2c_dut_pkg::*;

  logic system_clock = 1'b0;
  logic reset_n      = 1'b0;
  logic drv_sda      = 1'b0;   // 1 = controller pulls sda low
  logic drv_scl      = 1'b0;   // 1 = controller pulls scl low
  tri1  sda_bus, scl_bus;

  assign sda_bus = drv_sda ? 1'b0 : 1'bz;
  assign scl_bus = drv_scl ? 1'b0 : 1'bz;

  always #5 system_clock = ~system_clock;

  i2c_dut #(.DEV_ADDR(7'h50), .NUM_REGS(16), .STRETCH_CYCLES(8)) dut (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .sda          (sda_bus),
    .scl          (scl_bus)
  );

  // independent monitor counting bus START/STOP conditions
  i2c_dut_if mon_if ();
  i2c_bus_sync u_mon (
    .clk   (system_clock),
    .rst_n (reset_n),
    .scl   (scl_bus),
    .sda   (sda_bus),
    .bus   (mon_if)
  );

  int n_assert = 0, n_fail = 0;
  int n_start_seen = 0, n_stop_seen = 0, n_start_exp = 0, n_stop_exp = 0;
  int n_scl_held = 0;

  always @(posedge system_clock) begin
    if (mon_if.start) n_start_seen <= n_start_seen + 1;
    if (mon_if.stop)  n_stop_seen  <= n_stop_seen + 1;
  end

  // cycles where scl is low although the controller is not pulling it
  always @(negedge system_clock)
    if (scl_bus === 1'b0 && !drv_scl) n_scl_held <= n_scl_held + 1;

`ifdef I2C_DUT_CLK_STRETCH_EN
  int run = 0;
  int runs[$];
  always @(negedge system_clock) begin
    if (dut.scl_oe) run <= run + 1;
    else if (run != 0) begin
      runs.push_back(run);
      run <= 0;
    end
  end
`endif

  typedef struct { string tag; logic [7:0] val; } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, {24'd0, obs}, {24'd0, e.val});
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // release scl and wait (bounded) for it to actually go high
  task automatic scl_high();
    int t = 0;
    drv_scl = 1'b0;
    while (scl_bus !== 1'b1 && t < 200) begin
      @(negedge system_clock);
      t++;
    end
    if (scl_bus !== 1'b1) check("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
  endtask

  task automatic bit_clk(input logic b, output logic r);
    drv_sda = ~b;
    wait_n(5);
    scl_high();
    wait_n(10);
    r = sda_bus;
    drv_scl = 1'b1;
    wait_n(5);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] v, input logic exp_ack);
    logic r;
    sb_push(tag, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_clk(v[i], r);
    bit_clk(1'b1, r);
    sb_pop_check({7'd0, r});
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp, input logic ack);
    logic [7:0] v;
    logic r;
    sb_push(tag, exp);
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, r);
      v[i] = r;
    end
    sb_pop_check(v);
    bit_clk(ack, r);
  endtask

  task automatic i2c_start();
    drv_sda = 1'b1;
    wait_n(10);
    drv_scl = 1'b1;
    wait_n(5);
    n_start_exp++;
  endtask

  task automatic i2c_rstart();
    drv_sda = 1'b0;
    wait_n(5);
    scl_high();
    wait_n(10);
    i2c_start();
  endtask

  task automatic i2c_stop();
    drv_sda = 1'b1;
    wait_n(5);
    scl_high();
    wait_n(10);
    drv_sda = 1'b0;
    wait_n(10);
    n_stop_exp++;
  endtask

  // every stretch run since the last call must be exactly 8 clocks long
  task automatic check_stretch(input int n);
`ifdef I2C_DUT_CLK_STRETCH_EN
    check("stretch_runs", runs.size(), n);
    while (runs.size() > 0) check("stretch_len", runs.pop_front(), 32'd8);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    // reset state
    wait_n(5);
    check("rst_sda", {31'd0, sda_bus}, 32'd1);
    check("rst_scl", {31'd0, scl_bus}, 32'd1);
    check("rst_state", dut.state, ST_IDLE);
    check("rst_ptr", dut.ptr, 32'd0);
    reset_n = 1'b1;
    wait_n(5);

    // write 0xA5 to reg 3
    i2c_start();
    send_byte("w_addr_ack", 8'hA0, ACK);
    send_byte("w_ptr_ack", 8'h03, ACK);
    send_byte("w_data_ack", 8'hA5, ACK);
    i2c_stop();
    check("w_reg3", dut.regs[3], 32'hA5);
    check_stretch(3);

    // read reg 3 back through a repeated START
    i2c_start();
    send_byte("r_addr_ack", 8'hA0, ACK);
    send_byte("r_ptr_ack", 8'h03, ACK);
    i2c_rstart();
    send_byte("r_raddr_ack", 8'hA1, ACK);
    read_byte("r_data", 8'hA5, NACK);
    check("r_sda_rel_nack", {31'd0, sda_bus}, 32'd1);
    wait_n(20);
    check("r_sda_rel_later", {31'd0, sda_bus}, 32'd1);
    i2c_stop();
    check("r_ptr_inc", dut.ptr, 32'd4);
    check_stretch(4);

    // address mismatch: nothing ACKed, nothing written
    i2c_start();
    send_byte("m_addr_nack", 8'hA4, NACK);
    send_byte("m_data_nack", 8'h01, NACK);
    i2c_stop();
    check("m_reg1", dut.regs[1], 32'h00);
    check("m_reg3", dut.regs[3], 32'hA5);
    check("m_ptr", dut.ptr, 32'd4);
    check_stretch(0);

    // pointer wrap on write and read
    i2c_start();
    send_byte("wr_addr_ack", 8'hA0, ACK);
    send_byte("wr_ptr_ack", 8'h0F, ACK);
    send_byte("wr_d0_ack", 8'h11, ACK);
    send_byte("wr_d1_ack", 8'h22, ACK);
    i2c_stop();
    check("wr_reg15", dut.regs[15], 32'h11);
    check("wr_reg0", dut.regs[0], 32'h22);
    check("wr_ptr", dut.ptr, 32'd1);
    i2c_start();
    send_byte("wrr_addr_ack", 8'hA0, ACK);
    send_byte("wrr_ptr_ack", 8'h0F, ACK);
    i2c_rstart();
    send_byte("wrr_raddr_ack", 8'hA1, ACK);
    read_byte("wrr_d0", 8'h11, ACK);
    read_byte("wrr_d1", 8'h22, NACK);
    i2c_stop();
    check_stretch(9);

    // reset after 4 data bits of a write
    i2c_start();
    send_byte("rs_addr_ack", 8'hA0, ACK);
    send_byte("rs_ptr_ack", 8'h05, ACK);
    bit_clk(1'b0, r);
    bit_clk(1'b1, r);
    bit_clk(1'b0, r);
    bit_clk(1'b1, r);
    reset_n = 1'b0;
    wait_n(2);
    drv_sda = 1'b0;
    drv_scl = 1'b0;
    wait_n(3);
    check("rs_sda", {31'd0, sda_bus}, 32'd1);
    check("rs_scl", {31'd0, scl_bus}, 32'd1);
    check("rs_ptr", dut.ptr, 32'd0);
    check("rs_state", dut.state, ST_IDLE);
    for (int i = 0; i < 16; i++) check($sformatf("rs_reg%0d", i), dut.regs[i], 32'h00);
    reset_n = 1'b1;
    wait_n(5);
    // finish the interrupted byte without a START: must be ignored
    drv_scl = 1'b1;
    wait_n(5);
    sb_push("rs_ignored_ack", {7'd0, NACK});
    bit_clk(1'b1, r);
    bit_clk(1'b0, r);
    bit_clk(1'b1, r);
    bit_clk(1'b0, r);
    bit_clk(1'b1, r);
    sb_pop_check({7'd0, r});
    i2c_stop();
    check("rs_reg5_untouched", dut.regs[5], 32'h00);
    i2c_start();
    send_byte("rs2_addr_ack", 8'hA0, ACK);
    send_byte("rs2_ptr_ack", 8'h05, ACK);
    send_byte("rs2_data_ack", 8'h5A, ACK);
    i2c_stop();
    check("rs2_reg5", dut.regs[5], 32'h5A);
    check("rs2_reg3", dut.regs[3], 32'h00);
    check_stretch(5);

    check("mon_starts", n_start_seen, n_start_exp);
    check("mon_stops", n_stop_seen, n_stop_exp);
    check("sb_drained", sb.size(), 32'd0);
`ifdef I2C_DUT_CLK_STRETCH_EN
    check("scl_stretched", {31'd0, (n_scl_held > 0)}, 32'd1);
`else
    check("scl_never_held", n_scl_held, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_dut.md
I2C_DUT -- requirements
Module: i2c_dut

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning 7-bit target address answered on the bus.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning internal 8-bit register count (power of two).
REQ-003 SHALL have parameter STRETCH_CYCLES, default 8, meaning system_clock cycles SCL is held low per stretch.
REQ-004 SHALL have port system_clock  input  1  sole clock (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sda  inout  1  open-drain I2C data; driven only 1'b0 or 1'bz, never 1'b1 or x.
REQ-007 SHALL have port scl  inout  1  open-drain I2C clock; driven only 1'b0 or 1'bz, never 1'b1 or x.

Function
REQ-008 SHALL sample scl/sda through 2-flop synchronizers on system_clock; system_clock SHALL be at least 10x SCL rate.
REQ-009 SHALL detect START as synchronized sda falling while scl high, and STOP as sda rising while scl high.
REQ-010 SHALL sample data bits on synchronized scl rising edge, MSB first, and update its sda drive one cycle after synchronized scl falling edge.
REQ-011 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-012 SHALL go from IDLE to ADDR on START; any START (repeated START) in any state SHALL go to ADDR with bit counter cleared.
REQ-013 SHALL go to IDLE and release sda on STOP in any state.
REQ-014 SHALL, after 8 address bits, ACK (drive sda 0 for the 9th clock) if addr[7:1]==DEV_ADDR, else release sda and go to IGNORE until the next START/STOP.
REQ-015 SHALL, after an ACKed write address (R/W=0), take the first byte as register pointer (lower log2(NUM_REGS) bits used) and ACK it.
REQ-016 SHALL write each subsequent byte to regs[ptr], ACK it, then increment ptr modulo NUM_REGS.
REQ-017 SHALL, after an ACKed read address (R/W=1), drive regs[ptr] MSB first, incrementing ptr modulo NUM_REGS after each byte.
REQ-018 SHALL sample the controller's ACK on the 9th clock of a read byte: ACK (0) -> send next byte; NACK (1) -> release sda, go to IGNORE.
REQ-019 SHALL keep ptr across STOP/START so a write of pointer followed by repeated-START read returns regs[ptr].
REQ-020 SHALL never drive sda during the address byte or during controller-driven ACK bits.

Reset
REQ-021 SHALL, on reset_n low, asynchronously release sda and scl (z), set state IDLE, ptr 0, bit counter 0, all regs 8'h00.
REQ-022 SHALL, when reset deasserts mid-transfer, ignore bus activity until the next START.

Configuration
REQ-023 SHALL, with I2C_DUT_CLK_STRETCH_EN defined, hold scl low for STRETCH_CYCLES system_clock cycles after each ACK/NACK bit's scl falling edge it sourced or sampled, then release.
REQ-024 SHALL, without I2C_DUT_CLK_STRETCH_EN, never drive scl (constant z).

Structure
REQ-025 SHALL place the state enum, ACK/NACK constants and the R/W bit position in package i2c_dut_pkg.
REQ-026 SHALL use one sub-module i2c_bus_sync providing synchronized scl/sda, scl rise/fall pulses and START/STOP pulses.

Verification
REQ-027 SHALL test write: START, 0xA0, 0x03, 0xA5, STOP -> three ACKs, regs[3]==0xA5.
REQ-028 SHALL test read: START, 0xA0, 0x03, Sr, 0xA1, read byte, NACK, STOP -> read byte 0xA5, sda released after NACK.
REQ-029 SHALL test address mismatch: START, 0xA4, 0x01, STOP -> address NACK (sda z), no register change.
REQ-030 SHALL test wrap: START, 0xA0, 0x0F, 0x11, 0x22, STOP -> regs[15]==0x11, regs[0]==0x22.
REQ-031 SHALL test reset mid-write after 4 data bits -> sda/scl z, all regs 0x00, next transfer ACKed normally.
REQ-032 SHALL test with I2C_DUT_CLK_STRETCH_EN: address ACK -> scl held low exactly 8 system_clock cycles, then released; sda/scl never 1'b1 or x.
